// File: rtl/fetch_unit.sv
// Small synchronous FIFO used as the fetch queue; head is read straight from the storage registers.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: the caller must not push when full or pop when empty; flush and reset empty it in one cycle.
//
// Ports: clk, reset (sync, active-high), flush (drop all entries), push_vld/push_dat (write),
//        pop_vld (advance head), head_dat (oldest entry), count (occupancy 0..DEPTH).
module fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2   // power of two so the pointers wrap naturally
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           push_vld,
    input  logic [WIDTH-1:0]               push_dat,
    input  logic                           pop_vld,
    output logic [WIDTH-1:0]               head_dat,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// Instruction fetch front end: owns the PC, issues one word read at a time, queues up to 2 returned words.
// Latency: request in the cycle it is issued; with 1-cycle memory a word reaches `instr` 2 cycles after its request.
// Backpressure: instr_ready low lets the queue fill; no request is issued while 2 words are held.
//
// Ports: clk, reset (sync, active-high); imem_req/imem_addr -> memory, imem_rvalid/imem_rdata <- memory;
//        instr/instr_pc/instr_valid/instr_ready towards decode; redirect/redirect_pc from the branch unit.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    // IDLE: nothing outstanding. WAIT: live request outstanding.
    // DROP: request outstanding that was overtaken by a redirect; its data is thrown away.
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    state_t       state;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_pc;
    logic [31:0]  target_pc;
    logic [1:0]   count;
    logic         push_vld;
    logic         pop_vld;
    fetch_entry_t push_dat;
    fetch_entry_t head_dat;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

    // Only one request in flight, and only when the queue can absorb its reply.
    assign imem_req  = (state == IDLE) && !reset && !redirect && (count < 2'd2);
    assign imem_addr = fetch_pc;

    // A redirect kills both the queue contents and any response landing in the same cycle.
    assign push_vld = (state == WAIT) && imem_rvalid && !redirect;
    assign pop_vld  = instr_valid && instr_ready && !redirect;
    assign push_dat = '{pc: req_pc, instr: imem_rdata};

    fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (2)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .count    (count)
    );

    // Decode-facing outputs depend only on queue registers.
    assign instr_valid = (count != 2'd0);
    assign instr       = instr_valid ? head_dat.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? head_dat.pc    : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= 32'h0;
        end else if (redirect) begin
            fetch_pc <= target_pc;
            case (state)
                IDLE:    state <= IDLE;
                // Outstanding request is now stale; if its reply is here already, just drop it.
                WAIT:    state <= imem_rvalid ? IDLE : DROP;
                DROP:    state <= imem_rvalid ? IDLE : DROP;
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (imem_req) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
